// File: rtl/rc_filter_pkg.sv
// Shared types, state encoding and saturation helper for the time-multiplexed RC filter.
package rc_filter_pkg;

  localparam int unsigned ALPHA_FRAC = 16;
  localparam int unsigned PROD_W     = 34;

  typedef logic signed [15:0]       sample_t;
  typedef logic signed [16:0]       diff_t;
  typedef logic        [15:0]       alpha_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [18:0]       sum_t;

  typedef enum logic [2:0] {StIdle, StDiff, StMul, StAcc, StDone} state_e;

  function automatic sample_t sat16(input sum_t v);
    if (v > sum_t'(32767)) begin
      return sample_t'(16'sh7fff);
    end else if (v < sum_t'(-32768)) begin
      return sample_t'(16'sh8000);
    end else begin
      return sample_t'(v[15:0]);
    end
  endfunction

endpackage

// File: rtl/rc_filter_mac.sv
// Shared subtract/multiply/accumulate datapath; one registered stage per enable.
module rc_filter_mac
  import rc_filter_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     diff_en,
  input  logic                     mul_en,
  input  logic                     acc_en,
  input  logic [CH_W-1:0]          ch,
  input  sample_t                  sample,
  input  alpha_t                   alpha,
  output logic [16*CHANNELS-1:0]   acc_flat
);

  diff_t   diff_q;
  prod_t   prod_q;
  sample_t acc_q [CHANNELS];
  sample_t acc_cur;
  sum_t    sum;

  assign acc_cur = acc_q[ch];
  // Slicing off the fraction of a signed product floors toward -inf.
  assign sum = sum_t'(acc_cur) + sum_t'($signed(prod_q[PROD_W-1:ALPHA_FRAC]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= '0;
      prod_q <= '0;
      for (int k = 0; k < CHANNELS; k++) acc_q[k] <= '0;
    end else begin
      if (diff_en) diff_q <= diff_t'(sample) - diff_t'(acc_cur);
      if (mul_en)  prod_q <= prod_t'(diff_q) * prod_t'($signed({1'b0, alpha}));
      if (acc_en)  acc_q[ch] <= sat16(sum);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_flat
    assign acc_flat[16*k +: 16] = acc_q[k];
  end

endmodule

// File: rtl/rc_low_pass_filter_scheduler.sv
// Frame scheduler: snapshots all channels, walks them through one shared MAC, publishes together.
module rc_low_pass_filter_scheduler
  import rc_filter_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter alpha_t      DEFAULT_ALPHA = 16'd307,
  parameter int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    I_RST,
  input  logic                    audio_clk_en,
  input  logic [16*CHANNELS-1:0]  in,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_addr,
  input  logic [15:0]             cfg_alpha,
  output logic                    cfg_ready,
  output logic [16*CHANNELS-1:0]  out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  sample_t                 in_q    [CHANNELS];
  alpha_t                  alpha_q [CHANNELS];
  logic [16*CHANNELS-1:0]  out_q, acc_flat;
  logic                    out_valid_q, overrun_q;
  logic                    diff_en, mul_en, acc_en, start, cfg_ok;

  assign start  = audio_clk_en && (state_q == StIdle);
  assign cfg_ok = cfg_we && (state_q == StIdle) && (32'(cfg_addr) < CHANNELS);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    diff_en = 1'b0;
    mul_en  = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (audio_clk_en) begin
          state_d = StDiff;
          ch_d    = '0;
        end
      end
      StDiff: begin
        diff_en = 1'b1;
        state_d = StMul;
      end
      StMul: begin
        mul_en  = 1'b1;
        state_d = StAcc;
      end
      StAcc: begin
        acc_en = 1'b1;
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = StDone;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = StDiff;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        in_q[k]    <= '0;
        alpha_q[k] <= DEFAULT_ALPHA;
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      out_valid_q <= (state_q == StDone);
      if (state_q == StDone) out_q <= acc_flat;
      if (start) begin
        for (int k = 0; k < CHANNELS; k++) in_q[k] <= sample_t'(in[16*k +: 16]);
      end
      if (cfg_ok) alpha_q[cfg_addr] <= cfg_alpha;
      // A dropped frame start outranks a simultaneous clear.
      if (audio_clk_en && (state_q != StIdle)) overrun_q <= 1'b1;
      else if (overrun_clr)                    overrun_q <= 1'b0;
    end
  end

  rc_filter_mac #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_mac (
    .clk      (clk),
    .rst      (I_RST),
    .diff_en  (diff_en),
    .mul_en   (mul_en),
    .acc_en   (acc_en),
    .ch       (ch_q),
    .sample   (in_q[ch_q]),
    .alpha    (alpha_q[ch_q]),
    .acc_flat (acc_flat)
  );

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign cfg_ready = (state_q == StIdle);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rc_low_pass_filter_scheduler.sv
// Directed, table-driven bench for the RC low-pass scheduler (4-channel main DUT, 3-channel bounds DUT).
module tb_rc_low_pass_filter_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe, cfg_we, overrun_clr;
  logic [63:0] in_bus, out_bus;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_alpha;
  logic        cfg_ready, out_valid, busy, overrun;

  logic        strobe3, cfg_we3;
  logic [47:0] in3, out3;
  logic [1:0]  cfg_addr3;
  logic [15:0] cfg_alpha3;
  logic        cfg_ready3, out_valid3, busy3, overrun3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rc_low_pass_filter_scheduler #(.CHANNELS(4)) dut (
    .clk          (clk),
    .I_RST        (rst),
    .audio_clk_en (strobe),
    .in           (in_bus),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_alpha    (cfg_alpha),
    .cfg_ready    (cfg_ready),
    .out          (out_bus),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  rc_low_pass_filter_scheduler #(.CHANNELS(3)) dut3 (
    .clk          (clk),
    .I_RST        (rst),
    .audio_clk_en (strobe3),
    .in           (in3),
    .cfg_we       (cfg_we3),
    .cfg_addr     (cfg_addr3),
    .cfg_alpha    (cfg_alpha3),
    .cfg_ready    (cfg_ready3),
    .out          (out3),
    .out_valid    (out_valid3),
    .busy         (busy3),
    .overrun      (overrun3),
    .overrun_clr  (1'b0)
  );

  typedef struct packed {
    logic [63:0] in_v;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] alpha;
    logic [63:0] exp_v;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_chans(input string tag, input logic [63:0] exp_v);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s out ch%0d", tag, k), longint'($signed(out_bus[16*k +: 16])),
            longint'($signed(exp_v[16*k +: 16])));
  endtask

  task automatic write_alpha(input logic [1:0] addr, input logic [15:0] a);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_alpha = a;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Strobe one frame (optionally with a same-cycle config write) and check latency and outputs.
  task automatic run_frame(input string tag, input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    in_bus = v.in_v; strobe = 1'b1;
    cfg_we = v.we; cfg_addr = v.addr; cfg_alpha = v.alpha;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        strobe = 1'b0; cfg_we = 1'b0;
        check({tag, " busy"}, longint'(busy), 1);
        check({tag, " cfg_ready"}, longint'(cfg_ready), 0);
      end
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, lat, 14);
    check_chans(tag, v.exp_v);
    @(negedge clk);
    check({tag, " out_valid pulse"}, longint'(out_valid), 0);
    check({tag, " busy after"}, longint'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, pulses;
    vec_t v;

    // frames: ch0 step a=0.5, ch1 -1 a=0.5, ch2 extremes a=65535, ch3 alpha written with strobe
    vecs[0] = '{in_v: pack4(16'd10000, 16'hffff, 16'h8000, 16'd0), we: 1'b0, addr: 2'd0,
                alpha: 16'd0, exp_v: pack4(16'd5000, 16'hffff, 16'h8000, 16'd0)};
    vecs[1] = '{in_v: pack4(16'd10000, 16'hffff, 16'd32767, 16'd0), we: 1'b0, addr: 2'd0,
                alpha: 16'd0, exp_v: pack4(16'd7500, 16'hffff, 16'd32766, 16'd0)};
    vecs[2] = '{in_v: pack4(16'd10000, 16'hffff, 16'h8000, 16'd0), we: 1'b0, addr: 2'd0,
                alpha: 16'd0, exp_v: pack4(16'd8750, 16'hffff, 16'h8000, 16'd0)};
    vecs[3] = '{in_v: pack4(16'd10000, 16'hffff, 16'h8000, 16'd1000), we: 1'b1, addr: 2'd3,
                alpha: 16'd65535, exp_v: pack4(16'd9375, 16'hffff, 16'h8000, 16'd999)};

    rst = 1'b1; strobe = 1'b0; cfg_we = 1'b0; overrun_clr = 1'b0;
    in_bus = '0; cfg_addr = '0; cfg_alpha = '0;
    strobe3 = 1'b0; cfg_we3 = 1'b0; in3 = '0; cfg_addr3 = '0; cfg_alpha3 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset out", longint'(out_bus), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset busy", longint'(busy), 0);
    check("reset overrun", longint'(overrun), 0);
    check("reset cfg_ready", longint'(cfg_ready), 1);

    write_alpha(2'd0, 16'd32768);
    write_alpha(2'd1, 16'd32768);
    write_alpha(2'd2, 16'd65535);

    for (int i = 0; i < 4; i++) run_frame($sformatf("frame%0d", i + 1), vecs[i]);

    // Overrun: second strobe 2 cycles later, a config write while busy, and clear+set together.
    lat = 0; pulses = 0;
    @(negedge clk);
    in_bus = pack4(16'd10000, 16'hffff, 16'h8000, 16'd1000); strobe = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      strobe = 1'b0; cfg_we = 1'b0; overrun_clr = 1'b0;
      if (n == 2) begin
        strobe = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_alpha = 16'd0;
      end
      if (n == 3) check("overrun set", longint'(overrun), 1);
      if (n == 5) begin
        strobe = 1'b1; overrun_clr = 1'b1;
      end
      if (n == 6) check("overrun set wins over clr", longint'(overrun), 1);
      if (out_valid) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
    check("overrun frame out_valid count", pulses, 1);
    check("overrun frame latency", lat, 14);
    check_chans("overrun frame", pack4(16'd9687, 16'hffff, 16'h8000, 16'd999));
    repeat (5) @(negedge clk);
    check("overrun sticky", longint'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun cleared", longint'(overrun), 0);

    // alpha[0] must still be 0.5 after the ignored busy-time write
    v = '{in_v: pack4(16'd10000, 16'hffff, 16'h8000, 16'd1000), we: 1'b0, addr: 2'd0,
          alpha: 16'd0, exp_v: pack4(16'd9843, 16'hffff, 16'h8000, 16'd999)};
    run_frame("post-busy-cfg", v);

    // Reset 5 cycles into a frame.
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset out", longint'(out_bus), 0);
    check("midreset busy", longint'(busy), 0);
    check("midreset out_valid", longint'(out_valid), 0);
    check("midreset cfg_ready", longint'(cfg_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midreset no out_valid", pulses, 0);
    v = '{in_v: pack4(16'd0, 16'd0, 16'd0, 16'd16384), we: 1'b0, addr: 2'd0,
          alpha: 16'd0, exp_v: pack4(16'd0, 16'd0, 16'd0, 16'd76)};
    run_frame("after reset", v);

    // 3-channel instance: address 3 is out of range, address 0 is live.
    @(negedge clk);
    cfg_we3 = 1'b1; cfg_addr3 = 2'd3; cfg_alpha3 = 16'd0;
    @(negedge clk);
    cfg_addr3 = 2'd0; cfg_alpha3 = 16'd65535;
    @(negedge clk);
    cfg_we3 = 1'b0;
    in3 = {16'd16384, 16'd16384, 16'd16384};
    strobe3 = 1'b1;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      strobe3 = 1'b0;
      if (out_valid3) begin
        lat = n;
        break;
      end
    end
    check("ch3dut latency", lat, 11);
    check("ch3dut out ch0", longint'($signed(out3[15:0])), 16383);
    check("ch3dut out ch1", longint'($signed(out3[31:16])), 76);
    check("ch3dut out ch2", longint'($signed(out3[47:32])), 76);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
